// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end for the 32-bit combinational ALU: fetches operands from a
// local register file, drives the ALU for one cycle, writes back and returns the result.
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [23:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_n,
    input  logic              alu_v,
    input  logic              alu_c,
    input  logic              alu_z,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [3:0]        resp_flags,
    output logic              resp_illegal
);

    localparam int         NREGS   = 2 ** REG_AW;
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_COMP = 4'b0011;

    typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1011: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic                accept;
    logic [3:0]          op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [3:0]          alu_op_q;
    logic [DATA_W-1:0]   res_q;
    logic [3:0]          cap_flags_q;
    logic [3:0]          flags_q;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   resp_data_q;
    logic [3:0]          resp_flags_q;
    logic                resp_illegal_q;

    // Instruction field decode; bits [9:8] are reserved and deliberately ignored.
    logic [3:0]          in_op;
    logic                in_imm_sel;
    logic [REG_AW-1:0]   in_rd, in_rs1, in_rs2;
    logic [7:0]          in_imm;
    logic                unused_reserved;
    logic [DATA_W-1:0]   opnd_a, opnd_b;
    logic                wb_en, flag_en;

    assign in_op           = instr[23:20];
    assign in_imm_sel      = instr[19];
    assign in_rd           = instr[18:16];
    assign in_rs1          = instr[15:13];
    assign in_rs2          = instr[12:10];
    assign in_imm          = instr[7:0];
    assign unused_reserved = ^instr[9:8];

    assign opnd_a = (in_rs1 == '0) ? '0 : regs_q[in_rs1];
    assign opnd_b = in_imm_sel       ? {{(DATA_W-8){1'b0}}, in_imm} :
                    (in_rs2 == '0)   ? '0 : regs_q[in_rs2];

    assign wb_en   = (op_q != OP_NOP) && (op_q != OP_COMP) && (rd_q != '0);
    assign flag_en = (op_q != OP_NOP);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        resp_valid  = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = op_is_legal(in_op) ? EXEC : RESP;
                end
            end
            EXEC: state_d = WB;
            WB:   state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the register file is reset along with the rest of the state, since r1..r7
    // are architecturally defined to read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= OP_NOP;
            rd_q           <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= OP_NOP;
            res_q          <= '0;
            cap_flags_q    <= '0;
            flags_q        <= '0;
            resp_data_q    <= '0;
            resp_flags_q   <= '0;
            resp_illegal_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every read in this block sees pre-edge values.
            case (state_q)
                IDLE: if (accept) begin
                    op_q <= in_op;
                    rd_q <= in_rd;
                    if (op_is_legal(in_op)) begin
                        alu_a_q  <= opnd_a;
                        alu_b_q  <= opnd_b;
                        alu_op_q <= in_op;
                    end else begin
                        resp_data_q    <= '0;
                        resp_flags_q   <= flags_q;
                        resp_illegal_q <= 1'b1;
                    end
                end
                EXEC: begin
                    res_q       <= alu_result;
                    cap_flags_q <= {alu_n, alu_v, alu_c, alu_z};
                    alu_op_q    <= OP_NOP;
                end
                WB: begin
                    if (wb_en)   regs_q[rd_q] <= res_q;
                    if (flag_en) flags_q      <= cap_flags_q;
                    resp_data_q    <= res_q;
                    resp_flags_q   <= flag_en ? cap_flags_q : flags_q;
                    resp_illegal_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign resp_data    = resp_data_q;
    assign resp_flags   = resp_flags_q;
    assign resp_illegal = resp_illegal_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing front end that drives the team's 32-bit combinational ALU: accepts encoded register-based instructions over a valid/ready handshake, reads operands from a local register file, presents A/B/opcode to the ALU, and captures the result and N/V/C/Z flags. Writes back to the register file and the flag register, then returns the result on a valid/ready response channel. This is the initiator side of the ALU's opcode/flag interface. It sits between the lab instruction source (bench or future fetch unit) and the ALU.

Parameters:
DATA_W, 32, operand/result width; fixed to match ALU.
REG_AW, 3, register address width (2**REG_AW registers, r0 hardwired zero).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
instr_valid  in  1  instruction offered.
instr_ready  out  1  block can accept instruction.
instr  in  24  [23:20] op, [19] imm_sel, [18:16] rd, [15:13] rs1, [12:10] rs2, [9:8] reserved (ignored), [7:0] imm8.
alu_a  out  DATA_W  ALU operand A.
alu_b  out  DATA_W  ALU operand B.
alu_op  out  4  ALU opcode.
alu_result  in  DATA_W  ALU result.
alu_n, alu_v, alu_c, alu_z  in  1 each  ALU flags.
resp_valid  out  1  response available.
resp_ready  in  1  consumer accepts response.
resp_data  out  DATA_W  result of completed instruction.
resp_flags  out  4  flag register {N,V,C,Z} after instruction.
resp_illegal  out  1  instruction had an undefined opcode.

Behaviour:
- Reset: FSM to IDLE; all registers r0..r7 = 0; flag register = 0; resp_valid = 0, resp_data = 0, resp_flags = 0, resp_illegal = 0; alu_a = alu_b = 0, alu_op = 4'b0000; instr_ready = 1 on the first cycle after reset deasserts.
- Legal ops: 0000 NOP, 0001 ADD, 0010 SUB, 0011 COMP, 0101 AND, 0110 OR, 0111 NOT, 1000 XOR, 1001 SLL, 1011 MOV. All others are illegal.
- Operand A = reg[rs1]. Operand B = imm_sel ? zero-extended imm8 : reg[rs2]. Reading r0 returns 0.
- FSM states:
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr and go to EXEC, or go straight to RESP if the op is illegal.
  - EXEC: alu_a, alu_b and alu_op are registered outputs driven for this cycle. At the end of the cycle, capture alu_result and the flags. Go to WB.
  - WB: write the captured result to reg[rd] unless op is NOP or COMP, or rd = 0. Update the flag register from the captured flags unless op is NOP. Go to RESP.
  - RESP: resp_valid = 1, with resp_data, resp_flags and resp_illegal held stable until resp_valid & resp_ready, then go to IDLE.
- Outputs outside EXEC: alu_op = 0000 (NOP), and alu_a/alu_b hold their last values.
- instr_ready = 0 in EXEC, WB and RESP. There is no pipelining; one instruction is in flight at a time.
- Latency, legal op: handshake edge at cycle 0, resp_valid high in cycle 3. A new instruction can be accepted in the cycle after the response handshake.
- Latency, illegal op: resp_valid in cycle 1. resp_data = 0, resp_illegal = 1, resp_flags = current flag register (unchanged). No register or flag write.
- NOP and COMP: resp_data = captured ALU result (0). COMP updates the flag register, so Z reflects A==B.
- resp_flags in RESP = the flag register value after the WB update.
- Write to rd = 0 is silently dropped; r0 always reads 0.
- Reset mid-operation (any state) takes priority over everything. Next cycle is IDLE with registers, flags and response cleared, and any pending writeback is suppressed.
- Reserved bits [9:8] have no effect.

Test Plan:
- After reset, instr ADD r1 = r0 + imm 0x05 → resp_valid 3 cycles after accept, resp_data = 0x00000005, resp_flags = 4'b0000, resp_illegal = 0.
- SUB r2 = r0 − imm 0x01 → resp_data = 0xFFFFFFFF, resp_flags N=1, V=0, C=1, Z=0. A subsequent MOV r3 = r2 returns 0xFFFFFFFF.
- COMP r1, r1 (r1 = 5) → resp_data = 0, Z=1. MOV r4 = r1 then returns 5, confirming COMP did not write rd.
- Op 4'b0100 → resp_valid 1 cycle after accept, resp_illegal = 1, resp_data = 0, resp_flags equal to the prior flags, no register changes.
- ADD r0 = r0 + imm 0x07, then MOV r5 = r0 → resp_data = 0 (r0 write dropped). With resp_ready held low 5 cycles: resp_* stable, instr_ready = 0, and the next instr is accepted the cycle after the handshake.
- Assert rst during EXEC of ADD r1 = r0 + 0x09 → next cycle IDLE, resp_valid = 0. MOV r6 = r1 returns 0 and resp_flags = 0.
